// File: rtl/seq_enable_seq_checker_if.sv
// Sample/result bundle for the +1 sequence checker.
// Source drives en/d/clear; checker returns tracking state.
interface seq_enable_seq_checker_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 4
);
  logic             en;
  logic [WIDTH-1:0] d;
  logic             clear;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [ERR_W-1:0] err_cnt;
  logic             locked;
  logic             mismatch;

  modport master (
    output en, d, clear,
    input  q, r, err_cnt, locked, mismatch
  );

  modport slave (
    input  en, d, clear,
    output q, r, err_cnt, locked, mismatch
  );
endinterface

// File: rtl/seq_enable_seq_checker.sv
// Receive-side checker for an enabled +1 counter stream.
// Locks on first sample, flags mismatches, realigns after one glitch.
module seq_enable_seq_checker #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_enable_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] r, r_n;
  logic [ERR_W-1:0] err, err_n, err_base;
  logic             mis, mis_n;
  logic             hit, miss;

  assign hit  = bus.en && (bus.d == q);
  assign miss = bus.en && (bus.d != q);

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HUNT:    if (bus.en) state_n = LOCKED;
      LOCKED:  if (miss)   state_n = RESYNC;
      RESYNC: begin
        if (hit)       state_n = LOCKED;
        else if (miss) state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  // Mismatches are only recorded once a sequence is being tracked.
  always_comb begin
    q_n      = q;
    mis_n    = 1'b0;
    err_base = bus.clear ? '0 : err;
    r_n      = bus.clear ? '0 : r;
    unique case (state)
      HUNT: begin
        if (bus.en) q_n = bus.d + 1'b1;
      end
      LOCKED: begin
        if (bus.en) q_n = q + 1'b1;
        if (miss)   mis_n = 1'b1;
      end
      RESYNC: begin
        if (hit)  q_n = q + 1'b1;
        if (miss) begin
          q_n   = bus.d + 1'b1;
          mis_n = 1'b1;
        end
      end
      default: q_n = q;
    endcase
    err_n = err_base;
    if (mis_n) begin
      r_n = bus.d;
      if (err_base != '1) err_n = err_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      r   <= '0;
      err <= '0;
      mis <= 1'b0;
    end else begin
      q   <= q_n;
      r   <= r_n;
      err <= err_n;
      mis <= mis_n;
    end
  end

  assign bus.q        = q;
  assign bus.r        = r;
  assign bus.err_cnt  = err;
  assign bus.mismatch = mis;
  assign bus.locked   = (state == LOCKED);

endmodule

// File: tb/tb_seq_enable_seq_checker.sv
// Table-driven bench for seq_enable_seq_checker.
// Expected outputs are queued at drive time and checked after the edge.
module tb_seq_enable_seq_checker;

  logic clk = 1'b0;
  logic rst;

  seq_enable_seq_checker_if #(.WIDTH(8), .ERR_W(4)) bus ();

  seq_enable_seq_checker #(.WIDTH(8), .ERR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       clear;
    logic [7:0] q;
    logic [7:0] r;
    logic [3:0] e;
    logic       l;
    logic       m;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string tag, logic rs, logic en,
                              logic [7:0] d, logic clr,
                              logic [7:0] q, logic [7:0] r,
                              logic [3:0] e, logic l, logic m);
    vec_t v;
    v.tag = tag; v.rst = rs; v.en = en; v.d = d; v.clear = clr;
    v.q = q; v.r = r; v.e = e; v.l = l; v.m = m;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t x;
    rst       = v.rst;
    bus.en    = v.en;
    bus.d     = v.d;
    bus.clear = v.clear;
    sb.push_back(v);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_cmp++;
    if (bus.q !== x.q || bus.r !== x.r || bus.err_cnt !== x.e ||
        bus.locked !== x.l || bus.mismatch !== x.m) begin
      n_bad++;
      $display("FAIL %s: got q=%0d r=%0d err=%0d lk=%0b mm=%0b want q=%0d r=%0d err=%0d lk=%0b mm=%0b",
               x.tag, bus.q, bus.r, bus.err_cnt, bus.locked, bus.mismatch,
               x.q, x.r, x.e, x.l, x.m);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ecnt;
    rst = 1'b1; bus.en = 1'b0; bus.d = '0; bus.clear = 1'b0;

    vecs.push_back(mk("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("idle", 0, 0, 8'(i + 3), 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lock10", 0, 1, 10, 0, 11, 0, 0, 1, 0));
    vecs.push_back(mk("trk11",  0, 1, 11, 0, 12, 0, 0, 1, 0));
    vecs.push_back(mk("trk12",  0, 1, 12, 0, 13, 0, 0, 1, 0));
    vecs.push_back(mk("trk13",  0, 1, 13, 0, 14, 0, 0, 1, 0));
    vecs.push_back(mk("rstw",   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lk254",  0, 1, 254, 0, 255, 0, 0, 1, 0));
    vecs.push_back(mk("w255",   0, 1, 255, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("w0",     0, 1, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk("w1",     0, 1, 1, 0, 2, 0, 0, 1, 0));
    vecs.push_back(mk("rstg",   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lk19",   0, 1, 19, 0, 20, 0, 0, 1, 0));
    vecs.push_back(mk("g99",    0, 1, 99, 0, 21, 99, 1, 0, 1));
    vecs.push_back(mk("g21",    0, 1, 21, 0, 22, 99, 1, 1, 0));
    vecs.push_back(mk("rstd",   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lk29",   0, 1, 29, 0, 30, 0, 0, 1, 0));
    vecs.push_back(mk("dg5",    0, 1, 5, 0, 31, 5, 1, 0, 1));
    vecs.push_back(mk("dg7",    0, 1, 7, 0, 8, 7, 2, 0, 1));
    vecs.push_back(mk("dhold",  0, 0, 9, 0, 8, 7, 2, 0, 0));
    vecs.push_back(mk("d50",    0, 1, 50, 0, 51, 7, 2, 1, 0));
    vecs.push_back(mk("clr",    0, 0, 0, 1, 51, 0, 0, 1, 0));
    vecs.push_back(mk("rsts",   1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("slk0",   0, 1, 0, 0, 1, 0, 0, 1, 0));
    ecnt = 0;
    for (int k = 0; k < 10; k++) begin
      ecnt++;
      vecs.push_back(mk("satL", 0, 1, 100, 0, 2, 100,
                        4'(ecnt > 15 ? 15 : ecnt), 0, 1));
      ecnt++;
      vecs.push_back(mk("satR", 0, 1, 100, 0, 101, 100,
                        4'(ecnt > 15 ? 15 : ecnt), 0, 1));
      vecs.push_back(mk("satH", 0, 1, 0, 0, 1, 100,
                        4'(ecnt > 15 ? 15 : ecnt), 1, 0));
    end
    vecs.push_back(mk("sathold", 0, 0, 0, 0, 1, 100, 15, 1, 0));
    vecs.push_back(mk("clrmis",  0, 1, 3, 1, 2, 3, 1, 0, 1));
    vecs.push_back(mk("midrst",  0, 1, 2, 0, 3, 3, 1, 1, 0));
    vecs.push_back(mk("rstmid",  1, 1, 9, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post7",   0, 1, 7, 0, 8, 0, 0, 1, 0));

    foreach (vecs[i]) apply(vecs[i]);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
